// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bundle: decoded instruction and stall controls in, registered copy plus perf counters out.
// master drives the decode-side inputs; slave is the pipeline register.
interface id_ex_pipe_reg_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned EXE_CMD_W  = 4,
    parameter int unsigned CNT_W      = 16
);
    logic                  freeze;
    logic                  hazard_detected;
    logic                  flush;

    logic                  branchEn_in;
    logic [EXE_CMD_W-1:0]  EXE_CMD_in;
    logic [1:0]            Branch_command_in;
    logic                  Is_Imm_in;
    logic                  ST_or_BNE_in;
    logic                  WB_EN_in;
    logic                  MEM_R_EN_in;
    logic                  MEM_W_EN_in;
    logic [DATA_W-1:0]     pc_in;
    logic [DATA_W-1:0]     val1_in;
    logic [DATA_W-1:0]     val2_in;
    logic [DATA_W-1:0]     imm_in;
    logic [REG_ADDR_W-1:0] src1_in;
    logic [REG_ADDR_W-1:0] src2_in;
    logic [REG_ADDR_W-1:0] dest_in;
    logic                  valid_in;

    logic                  branchEn_out;
    logic [EXE_CMD_W-1:0]  EXE_CMD_out;
    logic [1:0]            Branch_command_out;
    logic                  Is_Imm_out;
    logic                  ST_or_BNE_out;
    logic                  WB_EN_out;
    logic                  MEM_R_EN_out;
    logic                  MEM_W_EN_out;
    logic [DATA_W-1:0]     pc_out;
    logic [DATA_W-1:0]     val1_out;
    logic [DATA_W-1:0]     val2_out;
    logic [DATA_W-1:0]     imm_out;
    logic [REG_ADDR_W-1:0] src1_out;
    logic [REG_ADDR_W-1:0] src2_out;
    logic [REG_ADDR_W-1:0] dest_out;
    logic                  valid_out;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output freeze, hazard_detected, flush,
        output branchEn_in, EXE_CMD_in, Branch_command_in, Is_Imm_in, ST_or_BNE_in,
        output WB_EN_in, MEM_R_EN_in, MEM_W_EN_in,
        output pc_in, val1_in, val2_in, imm_in, src1_in, src2_in, dest_in, valid_in,
        input  branchEn_out, EXE_CMD_out, Branch_command_out, Is_Imm_out, ST_or_BNE_out,
        input  WB_EN_out, MEM_R_EN_out, MEM_W_EN_out,
        input  pc_out, val1_out, val2_out, imm_out, src1_out, src2_out, dest_out, valid_out,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  freeze, hazard_detected, flush,
        input  branchEn_in, EXE_CMD_in, Branch_command_in, Is_Imm_in, ST_or_BNE_in,
        input  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in,
        input  pc_in, val1_in, val2_in, imm_in, src1_in, src2_in, dest_in, valid_in,
        output branchEn_out, EXE_CMD_out, Branch_command_out, Is_Imm_out, ST_or_BNE_out,
        output WB_EN_out, MEM_R_EN_out, MEM_W_EN_out,
        output pc_out, val1_out, val2_out, imm_out, src1_out, src2_out, dest_out, valid_out,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with freeze, bubble insertion, branch squash
// and saturating stall/flush event counters.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned EXE_CMD_W  = 4,
    parameter int unsigned CNT_W      = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_pipe_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                  branch_en_q,   branch_en_d;
    logic [EXE_CMD_W-1:0]  exe_cmd_q,     exe_cmd_d;
    logic [1:0]            br_cmd_q,      br_cmd_d;
    logic                  is_imm_q,      is_imm_d;
    logic                  st_or_bne_q,   st_or_bne_d;
    logic                  wb_en_q,       wb_en_d;
    logic                  mem_r_en_q,    mem_r_en_d;
    logic                  mem_w_en_q,    mem_w_en_d;
    logic [DATA_W-1:0]     pc_q,          pc_d;
    logic [DATA_W-1:0]     val1_q,        val1_d;
    logic [DATA_W-1:0]     val2_q,        val2_d;
    logic [DATA_W-1:0]     imm_q,         imm_d;
    logic [REG_ADDR_W-1:0] src1_q,        src1_d;
    logic [REG_ADDR_W-1:0] src2_q,        src2_d;
    logic [REG_ADDR_W-1:0] dest_q,        dest_d;
    logic                  valid_q,       valid_d;
    logic [CNT_W-1:0]      stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q,   flush_cnt_d;

    logic stall_evt;
    assign stall_evt = (bus.freeze | bus.hazard_detected) & ~bus.flush;

    // Next-state: flush > freeze > hazard bubble > normal load
    always_comb begin
        branch_en_d = branch_en_q;
        exe_cmd_d   = exe_cmd_q;
        br_cmd_d    = br_cmd_q;
        is_imm_d    = is_imm_q;
        st_or_bne_d = st_or_bne_q;
        wb_en_d     = wb_en_q;
        mem_r_en_d  = mem_r_en_q;
        mem_w_en_d  = mem_w_en_q;
        pc_d        = pc_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        imm_d       = imm_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        dest_d      = dest_q;
        valid_d     = valid_q;

        if (bus.flush) begin
            branch_en_d = 1'b0;
            exe_cmd_d   = '0;
            br_cmd_d    = '0;
            is_imm_d    = 1'b0;
            st_or_bne_d = 1'b0;
            wb_en_d     = 1'b0;
            mem_r_en_d  = 1'b0;
            mem_w_en_d  = 1'b0;
            pc_d        = '0;
            val1_d      = '0;
            val2_d      = '0;
            imm_d       = '0;
            src1_d      = '0;
            src2_d      = '0;
            dest_d      = '0;
            valid_d     = 1'b0;
        end else if (!bus.freeze) begin
            pc_d   = bus.pc_in;
            val1_d = bus.val1_in;
            val2_d = bus.val2_in;
            imm_d  = bus.imm_in;
            src1_d = bus.src1_in;
            src2_d = bus.src2_in;
            dest_d = bus.dest_in;
            if (bus.hazard_detected) begin
                // Controller leaves MEM_R_EN/branchEn set on a hazard, so clear everything here
                branch_en_d = 1'b0;
                exe_cmd_d   = '0;
                br_cmd_d    = '0;
                is_imm_d    = 1'b0;
                st_or_bne_d = 1'b0;
                wb_en_d     = 1'b0;
                mem_r_en_d  = 1'b0;
                mem_w_en_d  = 1'b0;
                valid_d     = 1'b0;
            end else begin
                // Side-effecting controls only survive on a valid slot
                branch_en_d = bus.branchEn_in & bus.valid_in;
                exe_cmd_d   = bus.EXE_CMD_in;
                br_cmd_d    = bus.Branch_command_in;
                is_imm_d    = bus.Is_Imm_in;
                st_or_bne_d = bus.ST_or_BNE_in;
                wb_en_d     = bus.WB_EN_in & bus.valid_in;
                mem_r_en_d  = bus.MEM_R_EN_in & bus.valid_in;
                mem_w_en_d  = bus.MEM_W_EN_in & bus.valid_in;
                valid_d     = bus.valid_in;
            end
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (bus.flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_en_q <= 1'b0;
            exe_cmd_q   <= '0;
            br_cmd_q    <= '0;
            is_imm_q    <= 1'b0;
            st_or_bne_q <= 1'b0;
            wb_en_q     <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            pc_q        <= '0;
            val1_q      <= '0;
            val2_q      <= '0;
            imm_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            branch_en_q <= branch_en_d;
            exe_cmd_q   <= exe_cmd_d;
            br_cmd_q    <= br_cmd_d;
            is_imm_q    <= is_imm_d;
            st_or_bne_q <= st_or_bne_d;
            wb_en_q     <= wb_en_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
            pc_q        <= pc_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            imm_q       <= imm_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            dest_q      <= dest_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.branchEn_out       = branch_en_q;
    assign bus.EXE_CMD_out        = exe_cmd_q;
    assign bus.Branch_command_out = br_cmd_q;
    assign bus.Is_Imm_out         = is_imm_q;
    assign bus.ST_or_BNE_out      = st_or_bne_q;
    assign bus.WB_EN_out          = wb_en_q;
    assign bus.MEM_R_EN_out       = mem_r_en_q;
    assign bus.MEM_W_EN_out       = mem_w_en_q;
    assign bus.pc_out             = pc_q;
    assign bus.val1_out           = val1_q;
    assign bus.val2_out           = val2_q;
    assign bus.imm_out            = imm_q;
    assign bus.src1_out           = src1_q;
    assign bus.src2_out           = src2_q;
    assign bus.dest_out           = dest_q;
    assign bus.valid_out          = valid_q;
    assign bus.stall_cnt          = stall_cnt_q;
    assign bus.flush_cnt          = flush_cnt_q;
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register: sits directly downstream of the instruction-decode controller and the register file read.
- Each cycle it captures the decoded control bundle, operand values, immediate and register addresses, and presents them to the EXE stage and the forwarding unit.
- Supports hold (freeze), bubble insertion (hazard) and squash (branch flush).
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- DATA_W, 32, width of PC, operand and immediate fields
- REG_ADDR_W, 5, register-file address width
- EXE_CMD_W, 4, ALU command width; must match the controller EXE_CMD width
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  hold all registered contents (downstream stall)
- hazard_detected  in  1  load-use hazard; insert bubble
- flush  in  1  branch taken in EXE; squash instruction being captured
- branchEn_in  in  1  controller branch enable
- EXE_CMD_in  in  EXE_CMD_W  controller ALU command
- Branch_command_in  in  2  branch condition code
- Is_Imm_in, ST_or_BNE_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  controller flags
- pc_in  in  DATA_W  PC+1 of the decoded instruction
- val1_in, val2_in  in  DATA_W  register-file read data
- imm_in  in  DATA_W  sign-extended immediate
- src1_in, src2_in, dest_in  in  REG_ADDR_W  register addresses
- valid_in  in  1  IF/ID slot holds a real instruction
- all *_out  out  same widths  registered copies of the above inputs
- valid_out  out  1  EXE slot holds a real instruction
- stall_cnt  out  CNT_W  cycles with freeze or hazard_detected asserted (saturating)
- flush_cnt  out  CNT_W  cycles with flush asserted (saturating)

Behaviour:
- Reset (async, immediate on rst rising): every *_out, valid_out, stall_cnt and flush_cnt = 0. Release is sampled at the next clk edge.
- Latency: 1 cycle. A value on *_in at edge N appears on *_out after edge N.
- Priority per rising edge: rst > flush > freeze > hazard_detected > normal load.
- flush=1:
  - All control outputs (branchEn, EXE_CMD, Branch_command, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN) = 0; valid_out = 0.
  - Data/address outputs = 0 for determinism.
  - Overrides a simultaneous freeze or hazard.
- freeze=1 (no flush): every output register holds its value, including valid_out.
- hazard_detected=1 (no flush/freeze): bubble.
  - All control outputs = 0, including MEM_R_EN and branchEn, regardless of *_in values. The controller does not clear these two during a hazard.
  - valid_out = 0.
  - src1/src2/dest/pc/val/imm are still loaded; they are don't-care because the slot is invalid.
- Normal load: all outputs take *_in. valid_out = valid_in.
- Invariant: valid_out = 0 implies WB_EN_out = MEM_R_EN_out = MEM_W_EN_out = branchEn_out = 0.
  - This includes valid_in = 0 on a normal load, which forces those four controls to 0.
- Counters:
  - stall_cnt increments by 1 on each edge where (freeze | hazard_detected) and not flush.
  - flush_cnt increments by 1 on each edge with flush.
  - Both saturate at 2^CNT_W-1 (no wrap) and clear only on rst.
- Reset mid-operation: contents are discarded immediately. No partial state survives.

Test Plan:
- Reset: hold rst, drive all *_in non-zero -> all outputs 0. Deassert, load ADD (EXE_CMD_in=1, WB_EN_in=1, val1_in=5, val2_in=7, dest_in=3) -> next cycle outputs match, valid_out=1.
- Freeze: load LD (MEM_R_EN=1, imm=0x10), then freeze=1 for 3 cycles while the inputs change to ST -> outputs stay LD for 3 cycles, stall_cnt=3.
- Bubble: hazard_detected=1 with MEM_R_EN_in=1, branchEn_in=1 -> all control outputs 0, valid_out=0, stall_cnt increments.
- Flush priority: flush=1, freeze=1, hazard_detected=1 together with a BNE on the inputs -> all outputs 0, valid_out=0, flush_cnt=1, stall_cnt unchanged.
- Saturation: CNT_W=4, hold freeze 20 cycles -> stall_cnt reaches 15 and stays at 15.
- Async reset mid-stream: assert rst between clk edges during a freeze -> outputs and counters clear before the next edge.
